// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, transaction kinds
// and the bus word width.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_IFETCH = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2
    } mem_op_t;

    // Fetches and loads both read memory; only a store drives the write strobe.
    function automatic logic is_read_op(input mem_op_t op);
        return op != OP_STORE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory or bus
// bridge (slave).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ren;
    logic              mem_wen;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_ren,
        output mem_wen,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_ren,
        input  mem_wen,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Access-cycle watchdog: counts cycles spent waiting on mem_ready and flags
// the terminal count TIMEOUT-1. The counter saturates there.
module mem_arbiter_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic cnt_en,
    output logic tc
);

    localparam int               CNT_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (cnt_en && (count_q != TC_VAL)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store,
// one transaction at a time, with data given priority over fetch.
//
// state | meaning
// IDLE  | sample requests; data (store > load) beats fetch
// DACC  | data access in flight, strobes from latched op/addr/wdata
// IACC  | fetch access in flight, mem_ren from latched addr
// RESP  | one-cycle iready/dready pulse, no strobes
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              iren,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dren,
    input  logic              dwen,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              iready,
    output logic              dready,
    output logic              mem_err,
    mem_arbiter_if.master     mem
);

    arb_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;
    logic              err_q, err_d;
    logic              in_access;
    logic              wd_tc;

    assign in_access = (state_q == DACC) || (state_q == IACC);

    // Held at zero while idle, so every access starts counting from 0.
    mem_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_arb_watchdog (
        .clk    (clk),
        .nRST   (nRST),
        .clr    (state_q == IDLE),
        .cnt_en (in_access),
        .tc     (wd_tc)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= OP_IFETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        iload_d = iload_q;
        dload_d = dload_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (dwen || dren) begin
                    op_d    = dwen ? OP_STORE : OP_LOAD;
                    addr_d  = daddr;
                    wdata_d = dstore;
                    state_d = DACC;
                end else if (iren) begin
                    op_d    = OP_IFETCH;
                    addr_d  = iaddr;
                    state_d = IACC;
                end
            end
            DACC, IACC: begin
                if (mem.mem_ready) begin
                    if (op_q == OP_IFETCH) iload_d = mem.mem_rdata;
                    if (op_q == OP_LOAD)   dload_d = mem.mem_rdata;
                    state_d = RESP;
                end else if (wd_tc) begin
                    // A timed-out read returns zero rather than whatever the bus shows.
                    if (op_q == OP_IFETCH) iload_d = '0;
                    if (op_q == OP_LOAD)   dload_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes and pulses decode straight from registers, so they are glitch-free
    // and drop immediately on async reset.
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_ren   = (state_q == IACC) || ((state_q == DACC) && is_read_op(op_q));
    assign mem.mem_wen   = (state_q == DACC) && (op_q == OP_STORE);

    assign iready  = (state_q == RESP) && (op_q == OP_IFETCH);
    assign dready  = (state_q == RESP) && (op_q != OP_IFETCH);
    assign iload   = iload_q;
    assign dload   = dload_q;
    assign mem_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory
// transactions and responses; independent monitors pop and compare.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        iren = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dren = 1'b0;
    logic        dwen = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        iready;
    logic        dready;
    logic        mem_err;

    mem_arbiter_if mem_bus ();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .nRST    (nRST),
        .iren    (iren),
        .iaddr   (iaddr),
        .dren    (dren),
        .dwen    (dwen),
        .daddr   (daddr),
        .dstore  (dstore),
        .iload   (iload),
        .dload   (dload),
        .iready  (iready),
        .dready  (dready),
        .mem_err (mem_err),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ren;
        logic        wen;
        int          cycles;
    } mem_txn_t;

    typedef struct {
        logic        is_i;
        logic [31:0] data;
        logic        err;
    } resp_t;

    mem_txn_t    exp_mem_q[$];
    resp_t       exp_resp_q[$];
    logic [31:0] mem_img[logic [31:0]];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_iload = '0;
    logic [31:0] exp_dload = '0;
    logic        exp_err = 1'b0;
    int          resp_lat = 1;
    int          resp_acc_n = 0;

    mem_txn_t    mon_cur;
    logic        mon_have = 1'b0;
    logic        mon_prev_act = 1'b0;
    int          mon_ncyc = 0;
    logic        mon_act;
    logic        prev_rdy = 1'b0;
    resp_t       mon_resp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: mem_ready on the resp_lat-th access cycle (0 = never).
    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_ren || mem_bus.mem_wen) begin
                resp_acc_n++;
                if (resp_lat > 0 && resp_acc_n == resp_lat) begin
                    mem_bus.mem_ready = 1'b1;
                    mem_bus.mem_rdata = (mem_bus.mem_ren && mem_img.exists(mem_bus.mem_addr)) ?
                                        mem_img[mem_bus.mem_addr] : 32'h0;
                end else begin
                    mem_bus.mem_ready = 1'b0;
                    mem_bus.mem_rdata = 32'hCAFE_F00D;
                end
            end else begin
                resp_acc_n        = 0;
                mem_bus.mem_ready = 1'b0;
                mem_bus.mem_rdata = '0;
            end
        end
    end

    // Memory-side monitor: strobe type, address/data stability, access length.
    initial begin
        forever begin
            @(negedge clk);
            mon_act = mem_bus.mem_ren || mem_bus.mem_wen;
            if (mon_act && !mon_prev_act) begin
                mon_ncyc = 0;
                if (exp_mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    mon_have = 1'b0;
                    $display("FAIL mem_unexpected_txn actual_addr=%h required=none", mem_bus.mem_addr);
                end else begin
                    mon_cur  = exp_mem_q.pop_front();
                    mon_have = 1'b1;
                    check("mem_ren", {31'b0, mem_bus.mem_ren}, {31'b0, mon_cur.ren});
                    check("mem_wen", {31'b0, mem_bus.mem_wen}, {31'b0, mon_cur.wen});
                end
            end
            if (mon_act) begin
                mon_ncyc++;
                if (mon_have) begin
                    check("mem_addr_stable", mem_bus.mem_addr, mon_cur.addr);
                    if (mon_cur.wen) check("mem_wdata_stable", mem_bus.mem_wdata, mon_cur.wdata);
                end
            end
            if (!mon_act && mon_prev_act && mon_have) begin
                check("access_cycles", mon_ncyc, mon_cur.cycles);
                mon_have = 1'b0;
            end
            mon_prev_act = mon_act;
        end
    end

    // Core-side monitor: every ready pulse must match the next expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (iready || dready) begin
                check("resp_both_ready", {31'b0, iready & dready}, 32'h0);
                check("resp_strobes_low", {31'b0, mem_bus.mem_ren | mem_bus.mem_wen}, 32'h0);
                check("resp_pulse_width", {31'b0, prev_rdy}, 32'h0);
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual_iready=%0b actual_dready=%0b required=none",
                             iready, dready);
                end else begin
                    mon_resp = exp_resp_q.pop_front();
                    check("resp_kind_iready", {31'b0, iready}, {31'b0, mon_resp.is_i});
                    if (mon_resp.is_i) check("iload", iload, mon_resp.data);
                    else               check("dload", dload, mon_resp.data);
                    check("resp_mem_err", {31'b0, mem_err}, {31'b0, mon_resp.err});
                end
            end
            prev_rdy = iready || dready;
        end
    end

    task automatic wait_ready(input logic want_i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_i ? iready : dready) && n < 60);
        checks++;
        if (!(want_i ? iready : dready)) begin
            errors++;
            $display("FAIL wait_ready_timeout actual=no_pulse required=%s", want_i ? "iready" : "dready");
        end
    endtask

    // lat = access cycle on which memory answers; 0 means never (watchdog expiry).
    task automatic access(input logic is_i, input logic is_st, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic perturb);
        mem_txn_t t;
        resp_t    r;
        t.addr   = addr;
        t.wdata  = wdata;
        t.ren    = !is_st;
        t.wen    = is_st;
        t.cycles = (lat > 0) ? lat : TIMEOUT;
        exp_mem_q.push_back(t);
        if (lat == 0) exp_err = 1'b1;
        r.is_i = is_i;
        r.err  = exp_err;
        if (is_st) begin
            r.data = exp_dload;
        end else begin
            r.data = (lat > 0) ? mem_img[addr] : 32'h0;
            if (is_i) exp_iload = r.data;
            else      exp_dload = r.data;
        end
        exp_resp_q.push_back(r);
        resp_lat = lat;
        @(negedge clk);
        if (is_i) begin
            iren  = 1'b1;
            iaddr = addr;
        end else begin
            dren   = 1'b1;
            dwen   = is_st;
            daddr  = addr;
            dstore = wdata;
        end
        @(negedge clk);
        if (perturb) begin
            iaddr  = ~addr;
            daddr  = ~addr;
            dstore = ~wdata;
        end
        if (!(is_i ? iready : dready)) wait_ready(is_i);
        iren = 1'b0;
        dren = 1'b0;
        dwen = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ren"},   {31'b0, mem_bus.mem_ren}, 32'h0);
        check({tag, "_mem_wen"},   {31'b0, mem_bus.mem_wen}, 32'h0);
        check({tag, "_iready"},    {31'b0, iready}, 32'h0);
        check({tag, "_dready"},    {31'b0, dready}, 32'h0);
        check({tag, "_mem_err"},   {31'b0, mem_err}, 32'h0);
        check({tag, "_iload"},     iload, 32'h0);
        check({tag, "_dload"},     dload, 32'h0);
        check({tag, "_mem_addr"},  mem_bus.mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_bus.mem_wdata, 32'h0);
    endtask

    initial begin
        int n;
        mem_img[32'h0000_0200] = 32'h00A0_0093;
        mem_img[32'h0000_0204] = 32'h0020_8133;
        mem_img[32'h0000_1000] = 32'h1234_5678;
        mem_img[32'h0000_0500] = 32'h1111_2222;
        mem_img[32'h0000_0600] = 32'h3333_4444;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        nRST = 1'b1;

        // Fetch, memory answers on the second access cycle.
        access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 1'b0);

        // Simultaneous load and fetch: load first, then fetch.
        exp_mem_q.push_back('{addr: 32'h0000_1000, wdata: 32'h0, ren: 1'b1, wen: 1'b0, cycles: 1});
        exp_mem_q.push_back('{addr: 32'h0000_0204, wdata: 32'h0, ren: 1'b1, wen: 1'b0, cycles: 1});
        exp_resp_q.push_back('{is_i: 1'b0, data: 32'h1234_5678, err: 1'b0});
        exp_resp_q.push_back('{is_i: 1'b1, data: 32'h0020_8133, err: 1'b0});
        exp_dload = 32'h1234_5678;
        exp_iload = 32'h0020_8133;
        resp_lat  = 1;
        @(negedge clk);
        iren  = 1'b1;
        iaddr = 32'h0000_0204;
        dren  = 1'b1;
        daddr = 32'h0000_1000;
        wait_ready(1'b0);
        dren = 1'b0;
        wait_ready(1'b1);
        iren = 1'b0;

        // Store with dren also set; dload must keep the earlier load value.
        access(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1, 1'b0);

        // Inputs change while the access is in flight.
        access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 3, 1'b1);
        access(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 2, 1'b1);
        access(1'b0, 1'b0, 32'h0000_0600, 32'h0, 2, 1'b1);

        // Async reset in the middle of a fetch.
        exp_mem_q.push_back('{addr: 32'h0000_0300, wdata: 32'h0, ren: 1'b1, wen: 1'b0, cycles: 1});
        resp_lat = 0;
        @(negedge clk);
        iren  = 1'b1;
        iaddr = 32'h0000_0300;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_bus.mem_ren && n < 10);
        check("midacc_ren_seen", {31'b0, mem_bus.mem_ren}, 32'h1);
        #2 nRST = 1'b0;
        #1 check_reset_outputs("midacc");
        iren      = 1'b0;
        exp_iload = '0;
        exp_dload = '0;
        @(negedge clk);
        nRST = 1'b1;

        // Watchdog expiry on a fetch, then mem_err must persist.
        access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("err_sticky_idle", {31'b0, mem_err}, 32'h1);

        nRST = 1'b0;
        #1 check("err_cleared_by_reset", {31'b0, mem_err}, 32'h0);
        exp_err = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        repeat (4) @(negedge clk);

        check("mem_queue_drained", exp_mem_q.size(), 32'h0);
        check("resp_queue_drained", exp_resp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
